switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//  Conditions one raw slide-switch/push-button pin before it reaches the Nios II
//  switch PIO input port. Synchronises the asynchronous pin, filters contact bounce
//  with a stability counter, and drives the clean level the PIO samples.
//  Also emits one-cycle edge pulses and a wrapping toggle counter for edge-capture/IRQ logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable clk cycles required to accept a new level (>=1)
//  RESET_LEVEL      1'b0   value of sync chain and sw_clean after reset
//  TOGGLE_W         8      width of toggle_count
// PORTS
//  clk           in   1         system clock (50 MHz board clock)
//  reset         in   1         async assert, active-high; synchronously deasserted upstream
//  sw_raw        in   1         raw pin, asynchronous to clk, may bounce
//  sw_clean      out  1         debounced level; drives the PIO in_port
//  rise_pulse    out  1         1-cycle pulse, same cycle sw_clean first reads 1
//  fall_pulse    out  1         1-cycle pulse, same cycle sw_clean first reads 0
//  toggle_count  out  TOGGLE_W  count of accepted level changes, wraps at 2^TOGGLE_W
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-high.
//  Reset values: sync_q1 = sync_q2 = sw_clean = RESET_LEVEL; stab_cnt = 0;
//   rise_pulse = fall_pulse = 0; toggle_count = 0.
//  Synchroniser: 2 FFs, sw_raw -> sync_q1 -> sync_q2. No logic between them.
//  Counter (stab_cnt, width CNT_W = $clog2(DEBOUNCE_CYCLES+1)):
//   - sync_q2 == sw_clean : stab_cnt <= 0 (any bounce back restarts the window).
//   - sync_q2 != sw_clean and stab_cnt == DEBOUNCE_CYCLES-1 : sw_clean <= sync_q2,
//     stab_cnt <= 0, toggle_count <= toggle_count + 1 (mod 2^TOGGLE_W).
//   - else stab_cnt <= stab_cnt + 1. stab_cnt never exceeds DEBOUNCE_CYCLES-1.
//  Latency: clean step on sw_raw -> sw_clean changes exactly 2 + DEBOUNCE_CYCLES
//   rising edges later. DEBOUNCE_CYCLES = 1 -> 3 edges, no filtering beyond sync.
//  Pulses: registered; rise_pulse <= (accept && sync_q2==1), fall_pulse <= (accept &&
//   sync_q2==0), i.e. they assert in the same cycle as the new sw_clean. Never both
//   high. Minimum spacing between pulses = DEBOUNCE_CYCLES cycles.
//  Boundaries:
//   - Glitch shorter than DEBOUNCE_CYCLES (post-sync): no sw_clean change, no pulse.
//   - Mismatch ending on the cycle the count would complete: not accepted.
//   - toggle_count at all-ones + accept -> 0, no sticky/overflow flag.
//   - reset mid-count: all state cleared immediately (async); after release, pin
//     re-filtered from RESET_LEVEL; a pin held opposite produces one edge pulse after
//     2 + DEBOUNCE_CYCLES cycles.
//   - Pin held steady at RESET_LEVEL through reset: no pulse ever.
//  No X-propagation: all regs reset; no combinational path sw_raw -> any output.
// STRUCTURE
//  Shared package (switch_io_pkg): DEBOUNCE_CYCLES_DEFAULT (50000 @ 50 MHz = 1 ms),
//   DEBOUNCE_CYCLES_SIM (4), TOGGLE_W_DEFAULT, and the CNT_W derivation function.
//  Sub-module: sync_2ff (generic 1-bit two-flop synchroniser, reset value parameter),
//   reused by other board-input conditioners. Counter/edge logic stays in this module.
// TESTING  (DEBOUNCE_CYCLES=4, RESET_LEVEL=0, TOGGLE_W=8 unless stated)
//  1. Reset held, sw_raw=1 -> all outputs 0; release, sw_raw held 1 -> sw_clean=1 and
//     rise_pulse=1 on edge 6 after release, rise_pulse 0 next cycle, toggle_count=1.
//  2. sw_raw 0->1 for 3 cycles then back to 0 -> sw_clean stays 0, no pulses, count 0.
//  3. Bounce train 1,0,1,0,1 (1 cycle each) then steady 1 -> sw_clean rises exactly
//     6 edges after the final 0->1 transition; single rise_pulse.
//  4. Stable 1 then sw_raw 1->0 steady -> fall_pulse one cycle at edge 6, sw_clean=0,
//     rise_pulse never high simultaneously.
//  5. 256 accepted toggles from count 0 -> toggle_count wraps to 0x00; 255 -> 0xFF.
//  6. Assert reset when stab_cnt=2 during a 0->1 change -> outputs cleared same cycle;
//     after release change accepted 6 edges later, not earlier.
//  Plus DEBOUNCE_CYCLES=1 run: step on sw_raw -> sw_clean follows at edge 3.

Source files
------------

// File: rtl/switch_io_pkg.sv
// Shared constants for board-input conditioners feeding the Nios II PIO.
// Holds debounce timing defaults and the stability-counter width rule.
package switch_io_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;
    localparam int TOGGLE_W_DEFAULT        = 8;

    // Counter must hold values up to DEBOUNCE_CYCLES.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debouncer_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a configurable reset value.
// Nothing sits between the two flops.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic q1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces one raw switch pin for the PIO in_port and reports
// accepted level changes as edge pulses plus a wrapping toggle count.
module switch_debouncer
    import switch_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   TOGGLE_W        = TOGGLE_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sw_raw,
    output logic                sw_clean,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [TOGGLE_W-1:0] toggle_count
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q2;
    logic [CNT_W-1:0] stab_cnt;
    logic             differ;
    logic             accept;

    sync_2ff #(
        .RESET_VAL(RESET_LEVEL)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sw_raw),
        .q    (sync_q2)
    );

    assign differ = (sync_q2 != sw_clean);
    assign accept = differ && (stab_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_clean     <= RESET_LEVEL;
            stab_cnt     <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            toggle_count <= '0;
        end else begin
            rise_pulse <= accept && sync_q2;
            fall_pulse <= accept && !sync_q2;
            // Any return to the current level restarts the window.
            if (!differ) begin
                stab_cnt <= '0;
            end else if (accept) begin
                sw_clean     <= sync_q2;
                stab_cnt     <= '0;
                toggle_count <= toggle_count + 1'b1;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule
